// File: rtl/stopwatch_pkg.sv
// -----------------------------------------------------------------------------
// stopwatch_pkg
// Shared constants and helpers for the stopwatch time base.
//   DIGIT_W       : width of one BCD digit (4 bits)
//   MM_SS_MODULI  : default packed moduli, mod 10, 6, 10, 6 (mm:ss), digit 0 in [3:0]
//   modulus_of()  : extracts the modulus field of digit idx from a packed vector
// -----------------------------------------------------------------------------
package stopwatch_pkg;

    localparam int          DIGIT_W      = 4;
    localparam logic [15:0] MM_SS_MODULI = 16'h6A6A;

    // Field idx of a packed moduli vector (up to 8 digits, zero-extended by caller).
    function automatic logic [3:0] modulus_of(input logic [31:0] moduli, input int idx);
        return moduli[4*idx +: 4];
    endfunction

endpackage

// File: rtl/modn_digit.sv
// -----------------------------------------------------------------------------
// modn_digit
// One modulo-MODULUS digit register of the cascade.
// Optional feature macro: MODN_DOWN_EN (enables down counting; otherwise up_i
// is ignored and the digit counts up only).
// Ports:
//   clk_i        rising-edge clock
//   reset_i      synchronous active-high reset, clears the digit
//   step_i       advance this digit by one (ripple enable from lower digits)
//   up_i         1 = count up, 0 = count down (MODN_DOWN_EN builds only)
//   load_i       parallel load strobe, overrides step_i
//   load_val_i   value to load; out-of-range values load 0
//   value_o      current digit value (registered)
//   terminal_o   digit sits at its terminal value for the current direction
//   range_err_o  load_val_i is >= MODULUS (combinational)
// -----------------------------------------------------------------------------
module modn_digit
    import stopwatch_pkg::*;
#(
    parameter logic [3:0] MODULUS = 4'd10
) (
    input  logic         clk_i,
    input  logic         reset_i,
    input  logic         step_i,
    input  logic         up_i,
    input  logic         load_i,
    input  logic [3:0]   load_val_i,
    output logic [3:0]   value_o,
    output logic         terminal_o,
    output logic         range_err_o
);

    localparam logic [3:0] MAX_VAL = MODULUS - 4'd1;

    logic [3:0] value_q;
    logic [3:0] value_d;
    logic       up_s;

`ifdef MODN_DOWN_EN
    assign up_s = up_i;
`else
    // Up-only build: direction input is tied off and never used.
    logic unused_up_s;
    assign unused_up_s = up_i;
    assign up_s        = 1'b1;
`endif

    assign range_err_o = (load_val_i >= MODULUS);
    assign value_o     = value_q;

`ifdef MODN_DOWN_EN
    assign terminal_o = up_s ? (value_q == MAX_VAL) : (value_q == 4'd0);
`else
    assign terminal_o = (value_q == MAX_VAL);
`endif

    // Next-state: load beats step; step wraps at the terminal value.
    always_comb begin
        value_d = value_q;
        if (load_i) begin
            value_d = range_err_o ? 4'd0 : load_val_i;
        end else if (step_i) begin
            if (up_s) begin
                value_d = (value_q == MAX_VAL) ? 4'd0 : (value_q + 4'd1);
            end else begin
`ifdef MODN_DOWN_EN
                value_d = (value_q == 4'd0) ? MAX_VAL : (value_q - 4'd1);
`else
                value_d = value_q;
`endif
            end
        end else begin
            value_d = value_q;
        end
    end

    // Digit register with synchronous reset.
    always_ff @(posedge clk_i) begin
        if (reset_i) begin
            value_q <= 4'd0;
        end else begin
            value_q <= value_d;
        end
    end

endmodule

// File: rtl/modn_cascade.sv
// -----------------------------------------------------------------------------
// modn_cascade
// Chain of DIGITS modulo-N digit counters forming the stopwatch time base.
// Optional feature macro: MODN_DOWN_EN (up/down counting; default up only).
// Parameters:
//   DIGITS   number of cascaded digits (1..8)
//   MODULI   packed per-digit moduli, 4 bits each, digit 0 in [3:0], each 2..10
// Ports:
//   clk_i        rising-edge clock
//   reset_i      synchronous active-high reset, clears all state
//   enable_i     count tick
//   up_i         1 = count up, 0 = count down
//   load_i       parallel load strobe (beats enable_i)
//   load_val_i   BCD load value, digit 0 in [3:0]
//   q_o          current digit values (registered)
//   tc_o         enable_i AND every digit terminal (combinational, for next stage)
//   overflow_o   sticky chain-wrap flag, cleared by reset or load
//   load_err_o   one-cycle pulse after a load with any out-of-range field
// -----------------------------------------------------------------------------
module modn_cascade
    import stopwatch_pkg::*;
#(
    parameter int                  DIGITS = 4,
    parameter logic [4*DIGITS-1:0] MODULI = MM_SS_MODULI
) (
    input  logic                  clk_i,
    input  logic                  reset_i,
    input  logic                  enable_i,
    input  logic                  up_i,
    input  logic                  load_i,
    input  logic [4*DIGITS-1:0]   load_val_i,
    output logic [4*DIGITS-1:0]   q_o,
    output logic                  tc_o,
    output logic                  overflow_o,
    output logic                  load_err_o
);

    // carry_s[i] is the step enable of digit i: enable AND all lower digits terminal.
    logic [DIGITS:0]   carry_s;
    logic [DIGITS-1:0] terminal_s;
    logic [DIGITS-1:0] range_err_s;

    logic overflow_q;
    logic overflow_d;
    logic load_err_q;
    logic load_err_d;

    assign carry_s[0] = enable_i;

    for (genvar i = 0; i < DIGITS; i++) begin : g_digit
        modn_digit #(
            .MODULUS (modulus_of(32'(MODULI), i))
        ) u_digit (
            .clk_i       (clk_i),
            .reset_i     (reset_i),
            .step_i      (carry_s[i]),
            .up_i        (up_i),
            .load_i      (load_i),
            .load_val_i  (load_val_i[4*i +: 4]),
            .value_o     (q_o[4*i +: 4]),
            .terminal_o  (terminal_s[i]),
            .range_err_o (range_err_s[i])
        );
        assign carry_s[i+1] = carry_s[i] & terminal_s[i];
    end

    // Whole chain terminal and enabled: the edge that wraps every digit.
    assign tc_o       = carry_s[DIGITS];
    assign overflow_o = overflow_q;
    assign load_err_o = load_err_q;

    // Flag next-state: load clears overflow and reports range errors; tc sets overflow.
    always_comb begin
        overflow_d = overflow_q;
        load_err_d = 1'b0;
        if (load_i) begin
            overflow_d = 1'b0;
            load_err_d = |range_err_s;
        end else if (tc_o) begin
            overflow_d = 1'b1;
        end else begin
            overflow_d = overflow_q;
        end
    end

    // Flag registers with synchronous reset.
    always_ff @(posedge clk_i) begin
        if (reset_i) begin
            overflow_q <= 1'b0;
            load_err_q <= 1'b0;
        end else begin
            overflow_q <= overflow_d;
            load_err_q <= load_err_d;
        end
    end

endmodule

// File: tb/tb_modn_cascade.sv
// -----------------------------------------------------------------------------
// tb_modn_cascade
// Self-checking bench: the chain is modelled as a single mixed-radix integer
// in 0..(product of moduli - 1); digits are derived by division.
// -----------------------------------------------------------------------------
module tb_modn_cascade;
    import stopwatch_pkg::*;

`ifdef MODN_DOWN_EN
    localparam bit DOWN_EN = 1'b1;
`else
    localparam bit DOWN_EN = 1'b0;
`endif

    localparam int ND = 4;

    logic        clk;
    logic        reset_i;
    logic        enable_i;
    logic        up_i;
    logic        load_i;
    logic [15:0] load_val_i;
    logic [15:0] q_o;
    logic        tc_o;
    logic        overflow_o;
    logic        load_err_o;

    int n_vec;
    int n_err;

    // reference model state
    int mods [ND];
    int total;
    int cnt;
    bit ovf_m;
    bit lerr_m;

    modn_cascade #(
        .DIGITS (ND),
        .MODULI (MM_SS_MODULI)
    ) dut (
        .clk_i      (clk),
        .reset_i    (reset_i),
        .enable_i   (enable_i),
        .up_i       (up_i),
        .load_i     (load_i),
        .load_val_i (load_val_i),
        .q_o        (q_o),
        .tc_o       (tc_o),
        .overflow_o (overflow_o),
        .load_err_o (load_err_o)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic check_val(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_vec++;
        if (obs !== exp) begin
            n_err++;
            $display("FAIL %s: got %h expected %h at %0t", tag, obs, exp, $time);
        end
    endtask

    function automatic logic [15:0] model_q(input int value);
        logic [15:0] r;
        int rem;
        r   = 16'h0000;
        rem = value;
        for (int i = 0; i < ND; i++) begin
            r[4*i +: 4] = 4'(rem % mods[i]);
            rem         = rem / mods[i];
        end
        return r;
    endfunction

    // One clock of stimulus, checking tc before the edge and registered outputs after.
    task automatic apply(input bit rst, input bit ld, input logic [15:0] lv, input bit en, input bit u);
        bit up_eff;
        bit tc_exp;
        int w;
        int nv;
        int f;
        bit err;
        reset_i    = rst;
        load_i     = ld;
        load_val_i = lv;
        enable_i   = en;
        up_i       = u;
        up_eff = DOWN_EN ? u : 1'b1;
        tc_exp = en && (up_eff ? (cnt == total - 1) : (cnt == 0));
        #1;
        check_val("tc", 32'(tc_o), 32'(tc_exp));
        @(posedge clk);
        if (rst) begin
            cnt = 0; ovf_m = 1'b0; lerr_m = 1'b0;
        end else if (ld) begin
            nv = 0; w = 1; err = 1'b0;
            for (int i = 0; i < ND; i++) begin
                f = int'(lv[4*i +: 4]);
                if (f >= mods[i]) begin
                    err = 1'b1;
                    f   = 0;
                end
                nv += f * w;
                w  *= mods[i];
            end
            cnt = nv; ovf_m = 1'b0; lerr_m = err;
        end else begin
            lerr_m = 1'b0;
            if (en) begin
                if (tc_exp) ovf_m = 1'b1;
                if (up_eff) cnt = (cnt + 1) % total;
                else        cnt = (cnt + total - 1) % total;
            end
        end
        #1;
        check_val("q", 32'(q_o), 32'(model_q(cnt)));
        check_val("overflow", 32'(overflow_o), 32'(ovf_m));
        check_val("load_err", 32'(load_err_o), 32'(lerr_m));
    endtask

    initial begin
        logic [15:0] mm;
        n_vec = 0;
        n_err = 0;
        mm    = MM_SS_MODULI;
        total = 1;
        for (int i = 0; i < ND; i++) begin
            mods[i] = int'(mm[4*i +: 4]);
            total  *= mods[i];
        end
        cnt = 0; ovf_m = 1'b0; lerr_m = 1'b0;
        reset_i = 1'b1; load_i = 1'b0; load_val_i = 16'h0000; enable_i = 1'b0; up_i = 1'b1;
        @(posedge clk);
        #1;

        // reset, then ten up-counts
        apply(1'b1, 1'b0, 16'h0000, 1'b0, 1'b1);
        check_val("reset_q", 32'(q_o), 32'h0000);
        for (int k = 0; k < 10; k++) apply(1'b0, 1'b0, 16'h0000, 1'b1, 1'b1);
        check_val("q_after_10", 32'(q_o), 32'h0010);

        // full-chain up wrap from 59:58
        apply(1'b0, 1'b1, 16'h5958, 1'b0, 1'b1);
        apply(1'b0, 1'b0, 16'h0000, 1'b1, 1'b1);
        check_val("q_5959", 32'(q_o), 32'h5959);
        apply(1'b0, 1'b0, 16'h0000, 1'b1, 1'b1);
        check_val("q_wrap_up", 32'(q_o), 32'h0000);
        check_val("ovf_wrap_up", 32'(overflow_o), 32'h1);

`ifdef MODN_DOWN_EN
        // full-chain down wrap from 00:00
        apply(1'b0, 1'b1, 16'h0000, 1'b0, 1'b0);
        apply(1'b0, 1'b0, 16'h0000, 1'b1, 1'b0);
        check_val("q_wrap_down", 32'(q_o), 32'h5959);
        check_val("ovf_wrap_down", 32'(overflow_o), 32'h1);
`endif

        // out-of-range load fields
        apply(1'b0, 1'b1, 16'h7A09, 1'b1, 1'b1);
        check_val("q_bad_load", 32'(q_o), 32'h0009);
        check_val("lerr_pulse", 32'(load_err_o), 32'h1);
        check_val("ovf_cleared", 32'(overflow_o), 32'h0);
        apply(1'b0, 1'b0, 16'h0000, 1'b0, 1'b1);
        check_val("lerr_one_cycle", 32'(load_err_o), 32'h0);

        // reset beats load and enable
        apply(1'b0, 1'b1, 16'h5959, 1'b0, 1'b1);
        apply(1'b1, 1'b1, 16'hFFFF, 1'b1, 1'b1);
        check_val("q_reset_prio", 32'(q_o), 32'h0000);

        // three down-requested counts from reset
        for (int k = 0; k < 3; k++) apply(1'b0, 1'b0, 16'h0000, 1'b1, 1'b0);
`ifdef MODN_DOWN_EN
        check_val("q_down3", 32'(q_o), 32'h5957);
`else
        check_val("q_up_only3", 32'(q_o), 32'h0003);
`endif

        // randomized traffic
        for (int k = 0; k < 600; k++) begin
            int r;
            logic [15:0] lv;
            r  = int'($urandom_range(0, 99));
            lv = 16'($urandom);
            if (r >= 10 && r < 14) lv = 16'h5959;
            if (r >= 14 && r < 18) lv = 16'h0000;
            apply(r < 2, (r >= 2 && r < 18), lv,
                  ($urandom_range(0, 3) != 0), 1'($urandom_range(0, 1)));
        end

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end

endmodule

// File: doc/modn_cascade.md
# modn_cascade

Parametrised chain of modulo-N digit counters forming the stopwatch time base, e.g. mm:ss. Each digit counts 0..MODULUS-1 and ripples a terminal-count enable into the next digit. Adds up/down counting, parallel load with per-digit validation, chain-level terminal count and a sticky overflow flag. Sits between the tick prescaler and the display decoder.

## Interface
- DIGITS, 4, number of cascaded digits (1..8)
- MODULI, 16'h6A6A, packed 4 bits per digit, digit 0 in bits [3:0]; each field 2..10; default gives mod 10, 6, 10, 6 (mm:ss)
- clk  input  1  rising-edge clock
- reset  input  1  synchronous, active-high; clears all state
- enable  input  1  count tick, one-cycle pulse or held
- up  input  1  1 = count up, 0 = count down
- load  input  1  parallel load strobe
- load_val  input  4*DIGITS  BCD value to load, digit 0 in [3:0]
- q  output  4*DIGITS  current digit values, registered
- tc  output  1  enable AND every digit at terminal value (combinational)
- overflow  output  1  sticky: whole chain has wrapped
- load_err  output  1  one-cycle pulse: a loaded digit was out of range

## Operation
- One clock, clk; reset is synchronous and active-high.
- Priority per cycle: reset > load > enable > hold.
- Digit i steps when enable AND digits 0..i-1 all at terminal value.
- Terminal value: MODULI[i]-1 when up=1, 0 when up=0.
- Up: at MODULI[i]-1 wraps to 0. Down: at 0 wraps to MODULI[i]-1.
- tc = enable AND all digits terminal; feeds the next cascade stage.
- overflow sets on the cycle tc=1 (registered with the wrap); cleared only by reset or load.
- Load: each digit takes load_val field; a field >= MODULI[i] loads 0 and that cycle's load_err=1 is registered (visible next cycle, one cycle wide). enable ignored during load.
- up may change any cycle; it takes effect on the next counting edge, with no extra state.

## Timing
- Reset values: q = 0, overflow = 0, load_err = 0; tc = 0 unless enable=1 and down mode (all zeros is terminal).
- q updates on the edge where enable/load is sampled; latency 1 cycle.
- tc is combinational from q, up and enable; no registered delay, so cascades see no skew.
- Full-chain wrap: q returns to all-terminal-complement value and overflow=1 on the same edge.
- Reset during load or enable: reset wins, all outputs to reset values next cycle.
- Held enable: one step per clock.

## Configuration
- MODN_DOWN_EN defined: up/down counting as above.
- Not defined: up is ignored, chain counts up only, down-wrap logic and down terminal compare omitted; tc is enable AND all digits at MODULI[i]-1.

## Structure
- Shared package stopwatch_pkg: digit width constant (4), default MODULI constant MM_SS_MODULI = 16'h6A6A, and a function returning field i of a packed moduli vector.
- Sub-module modn_digit: one digit register with modulus parameter, step input, up, load, load value; outputs value, terminal and range-error. modn_cascade generates DIGITS instances and the ripple-enable AND chain, tc, overflow and load_err OR-reduction.

## Test plan
- Reset then 10 enables, up=1 -> q = 16'h0010; tc never asserted.
- Load 16'h5958, up=1, two enables -> q = 16'h5959 then tc=1 with second enable... precisely: first enable gives 16'h5959, second enable with tc=1 gives q = 16'h0000, overflow=1.
- Load 16'h0000, up=0, one enable (MODN_DOWN_EN) -> tc=1 during enable, q = 16'h5959, overflow=1.
- Load 16'h7A09 -> q = 16'h0009, load_err=1 for exactly one cycle; overflow cleared.
- Reset asserted simultaneously with load=1 and enable=1 -> q = 0, overflow = 0, load_err = 0.
- Build without MODN_DOWN_EN, up=0, 3 enables from reset -> q = 16'h0003.
